cdb_bus_arbiter: RTL and testbench
==================================

// Module: cdb_bus_arbiter
// PURPOSE
//  Round-robin arbiter and transaction sequencer for the shared 22-bit Common Data Bus (CDB).
//  Collects bus requests from N_CORES snooping processor cores and grants the CDB to one core.
//  Broadcasts the winner's request word to all snoopers, then runs the snoop/abort/write-back window.
//  Signals completion to the owner and releases the bus. Sits between the cores and the CDB/memory.
// PARAMETERS
//  N_CORES      4    number of requesting cores (2..8)
//  REQ_W        22   request word width: {hdr[3:0], hit, rd(1)/wr(0), addr[15:0]}
//  SNOOP_CYCLES 1    cycles the snoop window stays open after broadcast (>=1)
//  WB_TIMEOUT   15   max cycles spent in WRITEBACK waiting for dataWB (>=1)
// PORTS
//  Clock      in   1              rising-edge clock
//  Resetn     in   1              asynchronous reset, active low
//  req_valid  in   N_CORES        per-core bus request; held high until its grant bit is seen
//  req_data   in   N_CORES*REQ_W  per-core request word; core i at [i*REQ_W +: REQ_W]
//  abortMem   in   1              a snooper holds the line dirty; memory response must be aborted
//  dataWB     in   1              dirty owner has completed its write-back
//  grant      out  N_CORES        one-hot grant, 1-cycle pulse
//  done       out  N_CORES        one-hot transaction-complete pulse to the owner, 1 cycle
//  CDB        out  REQ_W          bus word, held for the whole transaction, 0 when idle
//  cdb_valid  out  1              CDB carries a new request; 1-cycle pulse per transaction
//  bus_busy   out  1              high from grant through the DONE cycle, inclusive
//  wb_timeout out  1              1-cycle pulse when WRITEBACK exits on timeout
// BEHAVIOUR
//  Reset (Resetn=0, async): state=IDLE, rr_ptr=0, and every output is 0.
//   A transaction in flight is dropped; no done pulse is issued for it.
//  All outputs are registered. FSM states: IDLE, BROADCAST, SNOOP, WRITEBACK, DONE.
//  IDLE:
//   - If no req_valid bit is set, stay in IDLE.
//   - Otherwise the winner is the first set bit, searching from rr_ptr upward with wrap past N_CORES-1.
//   - At that edge: owner<=winner, grant[winner]<=1, CDB<=req_data[winner], cdb_valid<=1,
//     bus_busy<=1, and go to BROADCAST.
//   - Latency: a request seen at edge k produces grant and CDB at edge k.
//     They are visible during cycle k..k+1.
//  BROADCAST: grant<=0, cdb_valid<=0, cnt<=SNOOP_CYCLES-1, go to SNOOP. abortMem/dataWB are ignored here.
//  SNOOP (checked in this order, one action per edge):
//   1. abortMem=1 and dataWB=1: go to DONE (write-back already finished).
//   2. abortMem=1: cnt<=WB_TIMEOUT-1, go to WRITEBACK.
//   3. cnt==0: go to DONE.
//   4. Otherwise cnt<=cnt-1.
//  WRITEBACK: CDB is held.
//   - dataWB=1: go to DONE.
//   - Else if cnt==0: wb_timeout<=1 for 1 cycle, go to DONE.
//   - Else cnt<=cnt-1.
//  DONE:
//   - done[owner]<=1 for 1 cycle, CDB<=0, bus_busy<=0.
//   - rr_ptr<=(owner==N_CORES-1) ? 0 : owner+1.
//   - Go to IDLE. No grant is issued in the DONE cycle.
//  Minimum transaction: 4 cycles from grant to the next possible grant (SNOOP_CYCLES=1, no abort).
//  Fairness: a continuously requesting core waits at most N_CORES-1 transactions.
//  req_valid is ignored outside IDLE.
//   - A core that drops req_valid before it is granted forfeits silently.
//   - The owner must deassert req_valid after its grant. If it stays high, it is a new request,
//     arbitrated with the lowest priority.
//  req_data is sampled only at the grant edge; later changes do not affect CDB.
// TESTING
//  1. Reset, then req_valid=4'b0001 with data 22'h200ABC.
//     -> grant=0001 and CDB=22'h200ABC one cycle later; done[0] 3 cycles after grant; CDB=0 after.
//  2. req_valid=4'b1111 held high, each core re-requesting after its done.
//     -> grant order 0,1,2,3,0.
//  3. abortMem=1 in SNOOP, dataWB=1 three cycles later.
//     -> WRITEBACK held for 3 cycles, done 1 cycle after dataWB, CDB constant throughout.
//  4. abortMem=1 and dataWB never asserted, WB_TIMEOUT=15.
//     -> wb_timeout and done pulse on the same edge, 16 cycles after entering WRITEBACK.
//  5. Resetn pulled low during WRITEBACK.
//     -> all outputs 0 immediately; no done pulse; next request from core 2 arbitrated from rr_ptr=0.
//  6. Core 1 raises req_valid then drops it while core 0 owns the bus.
//     -> core 1 is never granted; bus returns to IDLE after core 0's done.

Source files
------------

// File: rtl/cdb_bus_arbiter_if.sv
// Interface between the snooping cores and the CDB arbiter.
// The master modport is the arbiter's view. The slave modport is the cores' and memory's view.
interface cdb_bus_arbiter_if #(
  parameter int N_CORES = 4,
  parameter int REQ_W   = 22
);
  logic [N_CORES-1:0]       req_valid;
  logic [N_CORES*REQ_W-1:0] req_data;
  logic                     abortMem;
  logic                     dataWB;
  logic [N_CORES-1:0]       grant;
  logic [N_CORES-1:0]       done;
  logic [REQ_W-1:0]         CDB;
  logic                     cdb_valid;
  logic                     bus_busy;
  logic                     wb_timeout;

  modport master (
    input  req_valid, req_data, abortMem, dataWB,
    output grant, done, CDB, cdb_valid, bus_busy, wb_timeout
  );

  modport slave (
    output req_valid, req_data, abortMem, dataWB,
    input  grant, done, CDB, cdb_valid, bus_busy, wb_timeout
  );
endinterface

// File: rtl/cdb_bus_arbiter.sv
// Round-robin arbiter and transaction sequencer for the shared Common Data Bus.
// It grants one core, broadcasts that core's request, and runs the snoop/write-back window.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | bus free; arbitrate req_valid starting from rr_ptr
// BROADCAST | request word on CDB; grant and cdb_valid pulses end here
// SNOOP     | snoop window open; abortMem diverts to WRITEBACK
// WRITEBACK | dirty owner writing back; bounded by WB_TIMEOUT
// DONE      | pulse done to the owner; clear the bus; advance rr_ptr
module cdb_bus_arbiter #(
  parameter int N_CORES      = 4,
  parameter int REQ_W        = 22,
  parameter int SNOOP_CYCLES = 1,
  parameter int WB_TIMEOUT   = 15
) (
  input  logic               Clock,
  input  logic               Resetn,
  cdb_bus_arbiter_if.master  bus
);

  localparam int PTR_W   = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int CNT_MAX = (WB_TIMEOUT > SNOOP_CYCLES) ? WB_TIMEOUT : SNOOP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {IDLE, BROADCAST, SNOOP, WRITEBACK, DONE} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [PTR_W-1:0]   owner, owner_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               timed_out, timed_out_nxt;
  logic [N_CORES-1:0] grant_q, grant_nxt;
  logic [N_CORES-1:0] done_q, done_nxt;
  logic [REQ_W-1:0]   cdb_q, cdb_nxt;
  logic               cdb_valid_q, cdb_valid_nxt;
  logic               busy_q, busy_nxt;
  logic               wb_to_q, wb_to_nxt;

  logic               found;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W:0]     cand;

  // The rotating search starts at rr_ptr. The first requester found wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < N_CORES; i++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(N_CORES)) cand = cand - (PTR_W+1)'(N_CORES);
      if (!found && bus.req_valid[cand[PTR_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[PTR_W-1:0];
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      cnt         <= '0;
      timed_out   <= 1'b0;
      grant_q     <= '0;
      done_q      <= '0;
      cdb_q       <= '0;
      cdb_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      wb_to_q     <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_ptr_nxt;
      owner       <= owner_nxt;
      cnt         <= cnt_nxt;
      timed_out   <= timed_out_nxt;
      grant_q     <= grant_nxt;
      done_q      <= done_nxt;
      cdb_q       <= cdb_nxt;
      cdb_valid_q <= cdb_valid_nxt;
      busy_q      <= busy_nxt;
      wb_to_q     <= wb_to_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    owner_nxt     = owner;
    cnt_nxt       = cnt;
    timed_out_nxt = timed_out;
    grant_nxt     = '0;
    done_nxt      = '0;
    cdb_nxt       = cdb_q;
    cdb_valid_nxt = 1'b0;
    busy_nxt      = busy_q;
    wb_to_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          owner_nxt         = winner;
          grant_nxt[winner] = 1'b1;
          cdb_nxt           = bus.req_data[int'(winner)*REQ_W +: REQ_W];
          cdb_valid_nxt     = 1'b1;
          busy_nxt          = 1'b1;
          timed_out_nxt     = 1'b0;
          state_nxt         = BROADCAST;
        end
      end
      BROADCAST: begin
        cnt_nxt   = CNT_W'(SNOOP_CYCLES - 1);
        state_nxt = SNOOP;
      end
      SNOOP: begin
        if (bus.abortMem && bus.dataWB) begin
          state_nxt = DONE;
        end else if (bus.abortMem) begin
          cnt_nxt   = CNT_W'(WB_TIMEOUT - 1);
          state_nxt = WRITEBACK;
        end else if (cnt == '0) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      WRITEBACK: begin
        if (bus.dataWB) begin
          state_nxt = DONE;
        end else if (cnt == '0) begin
          // The timeout is remembered so that wb_timeout pulses together with done.
          timed_out_nxt = 1'b1;
          state_nxt     = DONE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        done_nxt[owner] = 1'b1;
        wb_to_nxt       = timed_out;
        timed_out_nxt   = 1'b0;
        cdb_nxt         = '0;
        busy_nxt        = 1'b0;
        rr_ptr_nxt      = (owner == PTR_W'(N_CORES - 1)) ? '0 : owner + PTR_W'(1);
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.grant      = grant_q;
  assign bus.done       = done_q;
  assign bus.CDB        = cdb_q;
  assign bus.cdb_valid  = cdb_valid_q;
  assign bus.bus_busy   = busy_q;
  assign bus.wb_timeout = wb_to_q;

endmodule

// File: tb/tb_cdb_bus_arbiter.sv
// Directed testbench for cdb_bus_arbiter with N_CORES=4, SNOOP_CYCLES=1 and WB_TIMEOUT=15.
// Outputs are sampled 1 ns after each rising edge, and inputs are driven at the same point.
module tb_cdb_bus_arbiter;
  localparam int N = 4;
  localparam int W = 22;

  logic Clock  = 1'b0;
  logic Resetn = 1'b0;
  int   tests  = 0;
  int   fails  = 0;

  cdb_bus_arbiter_if #(.N_CORES(N), .REQ_W(W)) bus ();

  cdb_bus_arbiter #(.N_CORES(N), .REQ_W(W), .SNOOP_CYCLES(1), .WB_TIMEOUT(15)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus.master)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.grant, bus.done, bus.CDB, bus.cdb_valid, bus.bus_busy, bus.wb_timeout});
  endfunction

  // Advances until a grant appears. n is the number of edges taken, or 0 if none appeared.
  task automatic wait_grant(output int n);
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (bus.grant != '0) begin
        n = i;
        break;
      end
    end
    tests++;
    assert (n != 0) else begin
      fails++;
      $error("FAIL wait_grant: observed no grant expected grant within 12 cycles");
    end
  endtask

  task automatic do_reset();
    Resetn        = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.abortMem  = 1'b0;
    bus.dataWB    = 1'b0;
    tick();
    tick();
    chk("reset_outs", all_outs(), 64'h0);
    Resetn = 1'b1;
  endtask

  logic [W-1:0] dvals [N];
  int           order [5];
  int           n;

  initial begin
    dvals = '{22'h011111, 22'h122222, 22'h233333, 22'h344444};
    order = '{0, 1, 2, 3, 0};

    // Single request from core 0 with the minimum-length transaction.
    do_reset();
    bus.req_data[0 +: W] = 22'h200ABC;
    bus.req_valid        = 4'b0001;
    tick();
    chk("t1_grant", 64'(bus.grant), 64'h1);
    chk("t1_cdb", 64'(bus.CDB), 64'h200ABC);
    chk("t1_cdb_valid", 64'(bus.cdb_valid), 64'h1);
    chk("t1_busy", 64'(bus.bus_busy), 64'h1);
    bus.req_valid        = '0;
    bus.req_data[0 +: W] = 22'h3FFFFF;
    tick();
    chk("t1_grant_pulse", 64'(bus.grant), 64'h0);
    chk("t1_cdb_valid_pulse", 64'(bus.cdb_valid), 64'h0);
    chk("t1_cdb_held", 64'(bus.CDB), 64'h200ABC);
    tick();
    chk("t1_busy_done_state", 64'(bus.bus_busy), 64'h1);
    chk("t1_no_early_done", 64'(bus.done), 64'h0);
    tick();
    chk("t1_done", 64'(bus.done), 64'h1);
    chk("t1_cdb_cleared", 64'(bus.CDB), 64'h0);
    chk("t1_busy_cleared", 64'(bus.bus_busy), 64'h0);
    tick();
    chk("t1_done_pulse", 64'(bus.done), 64'h0);

    // All cores keep requesting. Grants rotate 0,1,2,3,0, each 4 cycles apart.
    do_reset();
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = dvals[i];
    bus.req_valid = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_grant(n);
      if (t > 0) chk("t2_gap", 64'(n), 64'h1);
      chk("t2_grant", 64'(bus.grant), 64'h1 << order[t]);
      chk("t2_cdb", 64'(bus.CDB), 64'(dvals[order[t]]));
      if (t == 4) bus.req_valid = '0;
      tick();
      tick();
      tick();
      chk("t2_done", 64'(bus.done), 64'h1 << order[t]);
    end

    // Core 2 (rr_ptr=1). abortMem in SNOOP, then dataWB three cycles later.
    bus.req_data[2*W +: W] = 22'h155AAA;
    bus.req_valid          = 4'b0100;
    wait_grant(n);
    chk("t3_grant", 64'(bus.grant), 64'h4);
    bus.req_valid = '0;
    tick();
    bus.abortMem = 1'b1;
    tick();
    bus.abortMem = 1'b0;
    chk("t3_wb_cdb0", 64'(bus.CDB), 64'h155AAA);
    tick();
    chk("t3_wb_cdb1", 64'(bus.CDB), 64'h155AAA);
    tick();
    chk("t3_wb_cdb2", 64'(bus.CDB), 64'h155AAA);
    chk("t3_wb_no_done", 64'(bus.done), 64'h0);
    bus.dataWB = 1'b1;
    tick();
    bus.dataWB = 1'b0;
    chk("t3_done_state_cdb", 64'(bus.CDB), 64'h155AAA);
    chk("t3_done_state_no_done", 64'(bus.done), 64'h0);
    tick();
    chk("t3_done", 64'(bus.done), 64'h4);
    chk("t3_no_timeout", 64'(bus.wb_timeout), 64'h0);

    // Core 3 (rr_ptr=3). abortMem and no dataWB, so the write-back times out.
    bus.req_valid = 4'b1000;
    wait_grant(n);
    chk("t4_grant", 64'(bus.grant), 64'h8);
    bus.req_valid = '0;
    tick();
    bus.abortMem = 1'b1;
    tick();
    bus.abortMem = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("t4_wait_done", 64'(bus.done), 64'h0);
      chk("t4_wait_timeout", 64'(bus.wb_timeout), 64'h0);
    end
    tick();
    chk("t4_done", 64'(bus.done), 64'h8);
    chk("t4_timeout", 64'(bus.wb_timeout), 64'h1);
    tick();
    chk("t4_timeout_pulse", 64'(bus.wb_timeout), 64'h0);

    // Core 0 (rr_ptr=0). abortMem and dataWB together in SNOOP go straight to DONE.
    bus.req_valid = 4'b0001;
    wait_grant(n);
    chk("t4b_grant", 64'(bus.grant), 64'h1);
    bus.req_valid = '0;
    tick();
    bus.abortMem = 1'b1;
    bus.dataWB   = 1'b1;
    tick();
    bus.abortMem = 1'b0;
    bus.dataWB   = 1'b0;
    tick();
    chk("t4b_done", 64'(bus.done), 64'h1);

    // Core 1 (rr_ptr=1). Reset arrives during WRITEBACK.
    bus.req_valid = 4'b0010;
    wait_grant(n);
    chk("t5_grant", 64'(bus.grant), 64'h2);
    bus.req_valid = '0;
    tick();
    bus.abortMem = 1'b1;
    tick();
    bus.abortMem = 1'b0;
    tick();
    chk("t5_in_wb_busy", 64'(bus.bus_busy), 64'h1);
    #2;
    Resetn = 1'b0;
    #1;
    chk("t5_async_clear", all_outs(), 64'h0);
    tick();
    tick();
    chk("t5_no_done", 64'(bus.done), 64'h0);
    Resetn        = 1'b1;
    bus.req_valid = 4'b0100;
    wait_grant(n);
    chk("t5_regrant", 64'(bus.grant), 64'h4);
    bus.req_valid = '0;
    tick();
    tick();
    tick();
    chk("t5_regrant_done", 64'(bus.done), 64'h4);

    // Core 1 requests briefly while core 0 owns the bus, then forfeits.
    bus.req_valid = 4'b0001;
    wait_grant(n);
    chk("t6_grant", 64'(bus.grant), 64'h1);
    bus.req_valid = '0;
    tick();
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = '0;
    tick();
    chk("t6_done", 64'(bus.done), 64'h1);
    tick();
    chk("t6_no_grant", 64'(bus.grant), 64'h0);
    chk("t6_idle_busy", 64'(bus.bus_busy), 64'h0);
    tick();
    tick();
    chk("t6_still_idle", all_outs(), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
